muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the execute stage, alongside the ALU. Takes the forwarded execute operands, computes a 64-bit MULT/MULTU product or a DIV/DIVU quotient and remainder over multiple cycles, and presents them as the HI/LO write data to the memory-stage pipeline register. `busy` drives the hazard unit's decode/fetch stall while an operation is in flight.

---
 rtl/pipeline_types_pkg.sv | 32 +++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_types_pkg.sv
// rtl/pipeline_types_pkg.sv - shared types and constants for the multiply/divide unit
package pipeline_types_pkg;

  typedef enum logic [1:0] {
    MULDIV_MULT  = 2'd0,
    MULDIV_MULTU = 2'd1,
    MULDIV_DIV   = 2'd2,
    MULDIV_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } muldiv_state_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } muldiv_mode_t;

  localparam int MULDIV_STEPS = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between execute stage and multiply/divide unit
interface muldiv_unit_if;
  import pipeline_types_pkg::*;

  logic        start;
  muldiv_op_t  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, kill,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, kill,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module muldiv_step
  import pipeline_types_pkg::*;
(
  input  muldiv_mode_t mode,
  input  logic [63:0]  acc,
  input  logic [31:0]  operand,
  output logic [63:0]  acc_next,
  output logic         q_bit
);

  logic [32:0] sum;
  logic [31:0] rem_sub;
  logic        rem_ge;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    sum     = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
    // Divide: acc = {remainder, dividend/quotient}; the shifted remainder needs 33 bits.
    rem_ge  = (acc[63:31] >= {1'b0, operand});
    rem_sub = acc[62:31] - operand;
    acc_next = '0;
    q_bit    = 1'b0;
    if (mode == STEP_MUL) begin
      acc_next = {sum, acc[31:1]};
    end else begin
      q_bit    = rem_ge;
      acc_next = {(rem_ge ? rem_sub : acc[62:31]), acc[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_unit
  import pipeline_types_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  muldiv_state_t state;
  muldiv_op_t    op_q;
  logic [63:0]   acc;
  logic [31:0]   opnd;
  logic [4:0]    count;
  logic          neg_res;
  logic          neg_rem;
  logic          fix_en;

  logic          req_div;
  logic          req_signed;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic          sign_diff;
  logic [63:0]   step_acc;
  logic          step_q;
  muldiv_mode_t  step_mode;
  logic [63:0]   mul_fixed;
  logic [31:0]   fix_hi;
  logic [31:0]   fix_lo;

  assign req_div    = (bus.op == MULDIV_DIV) || (bus.op == MULDIV_DIVU);
  assign req_signed = (bus.op == MULDIV_MULT) || (bus.op == MULDIV_DIV);
  assign abs_a      = abs32(bus.a, req_signed);
  assign abs_b      = abs32(bus.b, req_signed);
  assign sign_diff  = req_signed & (bus.a[31] ^ bus.b[31]);
  assign step_mode  = ((op_q == MULDIV_DIV) || (op_q == MULDIV_DIVU)) ? STEP_DIV : STEP_MUL;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] prod_fast;
  assign prod_fast = {32'd0, abs_a} * {32'd0, abs_b};
`endif

  muldiv_step u_step (
    .mode     (step_mode),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Sign correction; divide-by-zero results were loaded raw and bypass it.
  always_comb begin
    mul_fixed = neg_res ? (~acc + 64'd1) : acc;
    fix_hi    = acc[63:32];
    fix_lo    = acc[31:0];
    if (fix_en) begin
      if (step_mode == STEP_DIV) begin
        fix_hi = neg32(acc[63:32], neg_rem);
        fix_lo = neg32(acc[31:0], neg_res);
      end else begin
        fix_hi = mul_fixed[63:32];
        fix_lo = mul_fixed[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MD_IDLE;
      op_q     <= MULDIV_MULT;
      acc      <= '0;
      opnd     <= '0;
      count    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      fix_en   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (bus.start && !bus.kill) begin
            op_q     <= bus.op;
            count    <= 5'(MULDIV_STEPS - 1);
            neg_res  <= sign_diff;
            neg_rem  <= req_signed & bus.a[31] & req_div;
            fix_en   <= 1'b1;
            bus.busy <= 1'b1;
            if (req_div) begin
              if (bus.b == 32'd0) begin
                acc    <= {bus.a, 32'hFFFF_FFFF};
                fix_en <= 1'b0;
                state  <= MD_FIX;
              end else begin
                acc   <= {32'd0, abs_a};
                opnd  <= abs_b;
                state <= MD_RUN;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              acc   <= prod_fast;
              state <= MD_FIX;
`else
              acc   <= {32'd0, abs_b};
              opnd  <= abs_a;
              state <= MD_RUN;
`endif
            end
          end
        end
        MD_RUN: begin
          if (bus.kill) begin
            state    <= MD_IDLE;
            bus.busy <= 1'b0;
          end else begin
            acc <= step_acc | {63'd0, step_q};
            if (count == 5'd0) begin
              state <= MD_FIX;
            end else begin
              count <= count - 5'd1;
            end
          end
        end
        MD_FIX: begin
          state    <= MD_IDLE;
          bus.busy <= 1'b0;
          if (!bus.kill) begin
            bus.hi   <= fix_hi;
            bus.lo   <= fix_lo;
            bus.done <= 1'b1;
          end
        end
        default: begin
          state    <= MD_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  import pipeline_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      sa;
    longint      sb;
    longint      sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 34;
    case (op)
      2'd0: begin
        sp = sa * sb;
        up = sp;
        {hi, lo} = up;
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      default: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
          lat = 2;
        end else if (op == 2'd2) begin
          sp = sa / sb;
          lo = sp[31:0];
          sp = sa % sb;
          hi = sp[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
`ifdef MULDIV_FAST_MUL_EN
    if (op < 2'd2) lat = 2;
`endif
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eh;
    logic [31:0] el;
    int          lat;
    int          n;
    ref_model(op, a, b, eh, el, lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = muldiv_op_t'(op);
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd1);
    while (!bus.done && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, {eh, el});
    chk({tag, "_idle"}, {63'd0, bus.busy}, 64'd0);
    last_hi = eh;
    last_lo = el;
  endtask

  initial begin
    int seen_done;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.op    = MULDIV_MULT;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    chk("reset_state", {bus.busy, bus.done, 30'd0, bus.hi, bus.lo} >> 0, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    do_op(2'd3, 32'd7, 32'd2, "divu_small");
    do_op(2'd3, 32'h0000_1234, 32'd0, "divu_zero");
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(2'd2, 32'h8765_4321, 32'd0, "div_zero");
    do_op(2'd2, 32'd100, 32'hFFFF_FFF9, "div_negb");
    do_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_min");

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
      do_op(rop, ra, rb, "rand");
    end

    // kill and start together in IDLE: nothing may launch
    @(negedge clk);
    bus.start = 1'b1;
    bus.kill  = 1'b1;
    bus.op    = MULDIV_MULTU;
    @(negedge clk);
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    chk("kill_start_idle", {63'd0, bus.busy}, 64'd0);

    // kill mid-run with an ignored start while busy
    bus.start = 1'b1;
    bus.op    = MULDIV_MULTU;
    bus.a     = 32'd12345;
    bus.b     = 32'd678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MULDIV_DIVU;
    bus.b     = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("kill_idle", {63'd0, bus.busy}, 64'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    chk("kill_no_done", 64'(seen_done), 64'd0);
    chk("kill_hilo_kept", {bus.hi, bus.lo}, {last_hi, last_lo});

    // asynchronous reset mid-run
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MULDIV_DIV;
    bus.a     = 32'h7654_3210;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async", {bus.busy, bus.done, 30'd0, bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done++;
    end
    chk("rst_quiet", 64'(seen_done), 64'd0);

    do_op(2'd1, 32'd3, 32'd5, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
